// File: rtl/uart_hex_tx.sv
// Purpose: pops 4-bit nibbles from the nibble FIFO and sends each as its ASCII hex character in a UART 8N1 frame.
// Latency: the stop bit ends exactly 10*CLKS_PER_BIT clks after the pop edge. Back-to-back frames start 10*CLKS_PER_BIT+1 clks apart.
// Backpressure: pops only in IDLE when the FIFO is non-empty. A nibble pushed mid-frame waits until the frame finishes.
//
// Ports:
//   clk          system clock; all state changes on the rising edge
//   reset        asynchronous, active-high reset
//   fifo_data    FIFO read data (async read); valid whenever fifo_empty=0
//   fifo_empty   FIFO empty flag
//   fifo_rd      FIFO pop strobe, one clk wide per nibble; held low during reset
//   tx           UART serial line, registered, idles high
//   busy         high while a frame is in progress
//   tx_done_tick one-clk pulse in the last clk of the stop bit
module uart_hex_tx #(
    parameter int unsigned CLKS_PER_BIT = 868,
    parameter bit          UPPERCASE    = 1'b1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] fifo_data,
    input  logic       fifo_empty,
    output logic       fifo_rd,
    output logic       tx,
    output logic       busy,
    output logic       tx_done_tick
);

    localparam logic [15:0] LAST = 16'(CLKS_PER_BIT - 1);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t      state, state_nxt;
    logic [15:0] baud_cnt, baud_cnt_nxt;
    logic [2:0]  bit_cnt, bit_cnt_nxt;
    logic [7:0]  shreg, shreg_nxt;
    logic        tx_q, tx_nxt;

    // 0..9 -> '0'..'9'; 10..15 -> 'A'..'F' or 'a'..'f'.
    // The offsets 0x37 and 0x57 place nibble 10 on 0x41 and 0x61.
    function automatic logic [7:0] to_ascii(input logic [3:0] n);
        if (n < 4'd10)
            return 8'h30 + {4'h0, n};
        else if (UPPERCASE)
            return 8'h37 + {4'h0, n};
        else
            return 8'h57 + {4'h0, n};
    endfunction

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            baud_cnt <= '0;
            bit_cnt  <= '0;
            shreg    <= '0;
            tx_q     <= 1'b1;
        end else begin
            state    <= state_nxt;
            baud_cnt <= baud_cnt_nxt;
            bit_cnt  <= bit_cnt_nxt;
            shreg    <= shreg_nxt;
            tx_q     <= tx_nxt;
        end
    end

    always_comb begin
        state_nxt    = state;
        baud_cnt_nxt = baud_cnt;
        bit_cnt_nxt  = bit_cnt;
        shreg_nxt    = shreg;
        tx_nxt       = tx_q;
        case (state)
            IDLE: begin
                tx_nxt = 1'b1;
                if (!fifo_empty) begin
                    shreg_nxt    = to_ascii(fifo_data);
                    tx_nxt       = 1'b0;
                    baud_cnt_nxt = '0;
                    state_nxt    = START;
                end
            end
            START: begin
                if (baud_cnt == LAST) begin
                    baud_cnt_nxt = '0;
                    bit_cnt_nxt  = '0;
                    tx_nxt       = shreg[0];
                    state_nxt    = DATA;
                end else begin
                    baud_cnt_nxt = baud_cnt + 16'd1;
                end
            end
            DATA: begin
                if (baud_cnt == LAST) begin
                    baud_cnt_nxt = '0;
                    shreg_nxt    = {1'b0, shreg[7:1]};
                    // The increment wraps 7 -> 0 on the final bit, which is the DATA -> STOP edge.
                    bit_cnt_nxt  = bit_cnt + 3'd1;
                    if (bit_cnt == 3'd7) begin
                        tx_nxt    = 1'b1;
                        state_nxt = STOP;
                    end else begin
                        // The next bit is the one about to move into shreg[0].
                        tx_nxt = shreg[1];
                    end
                end else begin
                    baud_cnt_nxt = baud_cnt + 16'd1;
                end
            end
            STOP: begin
                if (baud_cnt == LAST) begin
                    baud_cnt_nxt = '0;
                    state_nxt    = IDLE;
                end else begin
                    baud_cnt_nxt = baud_cnt + 16'd1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // The reset term keeps the strobe low during reset.
    // Otherwise the FIFO would see a pop that this block never consumes.
    assign fifo_rd      = (state == IDLE) & ~fifo_empty & ~reset;
    assign tx           = tx_q;
    assign busy         = (state != IDLE);
    assign tx_done_tick = (state == STOP) && (baud_cnt == LAST);

endmodule

// File: tb/tb_uart_hex_tx.sv
module tb_uart_hex_tx;

    logic       clk;
    logic       reset;
    logic [3:0] fifo_data_u, fifo_data_l;
    logic       fifo_empty_u, fifo_empty_l;
    logic       fifo_rd_u, fifo_rd_l;
    logic       tx_u, tx_l;
    logic       busy_u, busy_l;
    logic       tick_u, tick_l;

    int n_checks = 0;
    int n_fail   = 0;

    uart_hex_tx #(.CLKS_PER_BIT(4), .UPPERCASE(1'b1)) dut_u (
        .clk          (clk),
        .reset        (reset),
        .fifo_data    (fifo_data_u),
        .fifo_empty   (fifo_empty_u),
        .fifo_rd      (fifo_rd_u),
        .tx           (tx_u),
        .busy         (busy_u),
        .tx_done_tick (tick_u)
    );

    uart_hex_tx #(.CLKS_PER_BIT(4), .UPPERCASE(1'b0)) dut_l (
        .clk          (clk),
        .reset        (reset),
        .fifo_data    (fifo_data_l),
        .fifo_empty   (fifo_empty_l),
        .fifo_rd      (fifo_rd_l),
        .tx           (tx_l),
        .busy         (busy_l),
        .tx_done_tick (tick_l)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_checks++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    // Entered at negedge+1 of an IDLE clk with a nibble waiting.
    // Checks the pop, then every clk of the frame against the expected byte.
    // Loads the next FIFO contents right after the pop edge.
    // Returns at negedge+1 of the IDLE clk that follows the frame.
    task automatic send_frame(input bit use_l, input logic [7:0] exp_byte,
                              input logic nxt_empty, input logic [3:0] nxt_data);
        check("rd_before_pop", use_l ? fifo_rd_l : fifo_rd_u, 1);
        @(posedge clk);
        @(negedge clk);
        if (use_l) begin
            fifo_empty_l = nxt_empty;
            fifo_data_l  = nxt_data;
        end else begin
            fifo_empty_u = nxt_empty;
            fifo_data_u  = nxt_data;
        end
        #1;
        for (int k = 1; k <= 40; k++) begin
            int   b;
            logic e;
            b = (k - 1) / 4;
            e = (b == 0) ? 1'b0 : (b == 9) ? 1'b1 : exp_byte[b-1];
            check($sformatf("tx_%02h_clk%0d", exp_byte, k), use_l ? tx_l : tx_u, e);
            check($sformatf("rd_busy_tick_%02h_clk%0d", exp_byte, k),
                  use_l ? {fifo_rd_l, busy_l, tick_l} : {fifo_rd_u, busy_u, tick_u},
                  {1'b0, 1'b1, (k == 40)});
            @(negedge clk);
            #1;
        end
        check($sformatf("idle_after_%02h", exp_byte),
              use_l ? {busy_l, tx_l} : {busy_u, tx_u}, 2'b01);
    endtask

    initial begin
        reset        = 1'b1;
        fifo_empty_u = 1'b0;
        fifo_data_u  = 4'hA;
        fifo_empty_l = 1'b1;
        fifo_data_l  = 4'h0;

        // Reset held while a nibble is waiting: outputs stay idle and no pop happens.
        repeat (3) @(negedge clk);
        #1;
        check("reset_u", {fifo_rd_u, tx_u, busy_u, tick_u}, 4'b0100);
        check("reset_l", {fifo_rd_l, tx_l, busy_l, tick_l}, 4'b0100);

        // Release reset. The pop strobe must appear in the first clk, followed by 0xA -> 'A' (0x41).
        @(negedge clk);
        reset = 1'b0;
        #1;
        send_frame(1'b0, 8'h41, 1'b1, 4'h0);

        // Lower-case instance, three nibbles back to back.
        @(negedge clk);
        fifo_empty_l = 1'b0;
        fifo_data_l  = 4'h3;
        #1;
        send_frame(1'b1, 8'h33, 1'b0, 4'hF);
        send_frame(1'b1, 8'h66, 1'b0, 4'h9);
        send_frame(1'b1, 8'h39, 1'b1, 4'h0);

        // Preloaded 0x1, 0x2. The pops fall 41 clks apart, with one idle clk between the frames.
        @(negedge clk);
        fifo_empty_u = 1'b0;
        fifo_data_u  = 4'h1;
        #1;
        send_frame(1'b0, 8'h31, 1'b0, 4'h2);
        send_frame(1'b0, 8'h32, 1'b1, 4'h0);

        // Empty FIFO for 200 clks: the block stays quiet.
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            #1;
            check($sformatf("empty_idle_%0d", i), {fifo_rd_u, tx_u, busy_u, tick_u}, 4'b0100);
        end

        // Reset pulse during data bit 3 of the frame for 0x5 ('5' = 0x35).
        @(negedge clk);
        fifo_empty_u = 1'b0;
        fifo_data_u  = 4'h5;
        #1;
        check("rd_pop5", fifo_rd_u, 1);
        @(posedge clk);
        @(negedge clk);
        fifo_empty_u = 1'b1;
        repeat (17) @(negedge clk);
        #1;
        check("bit3_before_reset", {busy_u, tx_u}, 2'b10);
        #2;
        reset = 1'b1;
        #1;
        check("mid_reset_tx_busy", {tx_u, busy_u}, 2'b10);
        fifo_data_u  = 4'h7;
        fifo_empty_u = 1'b0;
        #1;
        check("mid_reset_rd", fifo_rd_u, 0);
        @(negedge clk);
        reset = 1'b0;
        #1;
        send_frame(1'b0, 8'h37, 1'b1, 4'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
